// File: rtl/gpio_debounce.sv
// Per-bit synchroniser and debouncer for raw GPIO pins, with a Picoblaze-mapped bypass register.
// Optional GPIO_DEBOUNCE_EDGE_OUT_EN adds registered gpio_rise/gpio_fall pulse outputs.
module gpio_debounce #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [7:0]  BASE_ADDRESS    = 8'h08
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       port_id,
    input  logic [7:0]       data_in,
    input  logic             write_strobe,
    output logic [7:0]       data_out,
    input  logic [WIDTH-1:0] gpio_pins,
    output logic [WIDTH-1:0] gpio_clean
`ifdef GPIO_DEBOUNCE_EDGE_OUT_EN
    ,
    output logic [WIDTH-1:0] gpio_rise,
    output logic [WIDTH-1:0] gpio_fall
`endif
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];
    logic [WIDTH-1:0] clean_next;
    logic [WIDTH-1:0] bypass;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= gpio_pins;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // A matching sample anywhere in the run restarts the count; bypass forces the count to 0.
    always_comb begin
        clean_next = gpio_clean;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (bypass[i]) begin
                clean_next[i] = sync[i];
            end else if (sync[i] != gpio_clean[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    clean_next[i] = sync[i];
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
            gpio_clean <= '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
            gpio_clean <= clean_next;
        end
    end

`ifdef GPIO_DEBOUNCE_EDGE_OUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_rise <= '0;
            gpio_fall <= '0;
        end else begin
            gpio_rise <= clean_next & ~gpio_clean;
            gpio_fall <= ~clean_next & gpio_clean;
        end
    end
`endif

    // Read samples bypass before this edge's write lands, so a same-cycle write reads the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bypass   <= '0;
            data_out <= '0;
        end else begin
            if (write_strobe && port_id == BASE_ADDRESS) bypass <= WIDTH'(data_in);
            data_out <= (port_id == BASE_ADDRESS) ? 8'(bypass) : 8'h00;
        end
    end

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed self-checking bench for gpio_debounce: register vectors table plus latency/corner sequences.
// Edge-output checks are included when GPIO_DEBOUNCE_EDGE_OUT_EN is defined.
module tb_gpio_debounce;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] port_id = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       write_strobe = 1'b0;
    logic [7:0] data_out;
    logic [7:0] gpio_pins = 8'h00;
    logic [7:0] gpio_clean;
    logic [7:0] data_out_f;
    logic [7:0] clean_f;
`ifdef GPIO_DEBOUNCE_EDGE_OUT_EN
    logic [7:0] gpio_rise, gpio_fall, rise_f, fall_f;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpio_debounce #(
        .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .BASE_ADDRESS(8'h08)
    ) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .data_in(data_in),
        .write_strobe(write_strobe), .data_out(data_out),
        .gpio_pins(gpio_pins), .gpio_clean(gpio_clean)
`ifdef GPIO_DEBOUNCE_EDGE_OUT_EN
        , .gpio_rise(gpio_rise), .gpio_fall(gpio_fall)
`endif
    );

    // Second instance: pure synchroniser corner (DEBOUNCE_CYCLES=1, three sync stages).
    gpio_debounce #(
        .WIDTH(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .BASE_ADDRESS(8'h08)
    ) dut_fast (
        .clk(clk), .reset(reset), .port_id(port_id), .data_in(data_in),
        .write_strobe(write_strobe), .data_out(data_out_f),
        .gpio_pins(gpio_pins), .gpio_clean(clean_f)
`ifdef GPIO_DEBOUNCE_EDGE_OUT_EN
        , .gpio_rise(rise_f), .gpio_fall(fall_f)
`endif
    );

    typedef struct {
        logic       ws;
        logic [7:0] port;
        logic [7:0] din;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        port_id = a;
        data_in = d;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
    endtask

    // Count edges until the chosen clean bit reaches level; 99 means the bound expired.
    task automatic edges_to(input int sel, input int b, input logic level, output int n);
        logic obs;
        n = 99;
        for (int k = 1; k <= 60; k++) begin
            tick();
            obs = (sel == 0) ? gpio_clean[b] : clean_f[b];
            if (obs === level) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        logic stable;

        vecs[0]  = '{1'b0, 8'h08, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 8'h08, 8'h80, 8'h00};
        vecs[2]  = '{1'b0, 8'h08, 8'h00, 8'h80};
        vecs[3]  = '{1'b0, 8'h09, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 8'h09, 8'hFF, 8'h00};
        vecs[5]  = '{1'b0, 8'h08, 8'h00, 8'h80};
        vecs[6]  = '{1'b1, 8'h08, 8'h5A, 8'h80};
        vecs[7]  = '{1'b0, 8'h08, 8'h00, 8'h5A};
        vecs[8]  = '{1'b1, 8'h08, 8'h00, 8'h5A};
        vecs[9]  = '{1'b0, 8'h08, 8'h00, 8'h00};
        vecs[10] = '{1'b0, 8'h00, 8'h00, 8'h00};

        #12;
        check("reset_clean", 32'(gpio_clean), 32'h00);
        check("reset_data_out", 32'(data_out), 32'h00);
        tick();
        reset = 1'b1;
        tick();

        // Steady rise on bit 0, then fall
        gpio_pins = 8'h01;
        edges_to(0, 0, 1'b1, n);
        check("t1_rise_latency", 32'(n), 32'd18);
        check("t1_other_bits", 32'(gpio_clean), 32'h01);
        gpio_pins = 8'h00;
        edges_to(0, 0, 1'b0, n);
        check("t1_fall_latency", 32'(n), 32'd18);

        // DEBOUNCE_CYCLES=1 instance: SYNC_STAGES+1 latency
        gpio_pins = 8'h01;
        edges_to(1, 0, 1'b1, n);
        check("fast_rise_latency", 32'(n), 32'd4);
        gpio_pins = 8'h00;
        edges_to(1, 0, 1'b0, n);
        check("fast_fall_latency", 32'(n), 32'd4);
        repeat (5) tick();
        check("t1_bounce_ignored", 32'(gpio_clean), 32'h00);

        // Bit 3 toggling every 5 cycles never qualifies
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            gpio_pins[3] = ~gpio_pins[3];
            repeat (5) begin
                tick();
                if (gpio_clean[3] !== 1'b0) stable = 1'b0;
            end
        end
        check("t2_stable_while_toggling", 32'(stable), 32'd1);
        gpio_pins[3] = 1'b1;
        edges_to(0, 3, 1'b1, n);
        check("t2_rise_after_hold", 32'(n), 32'd18);
        gpio_pins[3] = 1'b0;
        edges_to(0, 3, 1'b0, n);
        check("t2_fall", 32'(n), 32'd18);

        // One low sample mid-count restarts the count
        gpio_pins[4] = 1'b1;
        repeat (10) tick();
        check("glitch_not_yet", 32'(gpio_clean), 32'h00);
        gpio_pins[4] = 1'b0;
        tick();
        gpio_pins[4] = 1'b1;
        edges_to(0, 4, 1'b1, n);
        check("glitch_restart_latency", 32'(n), 32'd18);
        gpio_pins[4] = 1'b0;
        edges_to(0, 4, 1'b0, n);
        check("glitch_fall", 32'(n), 32'd18);

        // Register vectors: write/read, foreign port, same-cycle write+read
        for (int v = 0; v < 11; v++) begin
            port_id = vecs[v].port;
            data_in = vecs[v].din;
            write_strobe = vecs[v].ws;
            tick();
            check($sformatf("reg_vec%0d", v), 32'(data_out), 32'(vecs[v].exp_out));
        end
        write_strobe = 1'b0;

        // Bypass on bit 7
        write_reg(8'h08, 8'h80);
        tick();
        check("t3_readback", 32'(data_out), 32'h80);
        gpio_pins[7] = 1'b1;
        edges_to(0, 7, 1'b1, n);
        check("t3_bypass_latency", 32'(n), 32'd3);
        gpio_pins[7] = 1'b0;
        edges_to(0, 7, 1'b0, n);
        check("t3_bypass_fall", 32'(n), 32'd3);

        // Setting bypass mid-count takes sync immediately; clearing resumes from zero
        write_reg(8'h08, 8'h00);
        gpio_pins[1] = 1'b1;
        repeat (8) tick();
        check("midcnt_pre", 32'(gpio_clean), 32'h00);
        write_reg(8'h08, 8'h02);
        check("midcnt_write_edge", 32'(gpio_clean), 32'h00);
        tick();
        check("midcnt_bypass_take", 32'(gpio_clean), 32'h02);
        write_reg(8'h08, 8'h00);
        gpio_pins[1] = 1'b0;
        edges_to(0, 1, 1'b0, n);
        check("bypass_clear_fall", 32'(n), 32'd18);

        // Asynchronous reset mid-count
        write_reg(8'h08, 8'h80);
        gpio_pins = 8'h84;
        repeat (10) tick();
        check("t4_pre_reset_clean", 32'(gpio_clean), 32'h80);
        check("t4_pre_reset_data", 32'(data_out), 32'h80);
        #3 reset = 1'b0;
        #1;
        check("t4_async_clean", 32'(gpio_clean), 32'h00);
        check("t4_async_data", 32'(data_out), 32'h00);
        tick();
        reset = 1'b1;
        edges_to(0, 2, 1'b1, n);
        check("t4_rise_after_release", 32'(n), 32'd18);
        check("t4_bypass_cleared", 32'(gpio_clean), 32'h84);
        check("t4_read_bypass", 32'(data_out), 32'h00);
        gpio_pins = 8'h00;
        repeat (20) tick();
        check("t4_settled", 32'(gpio_clean), 32'h00);

`ifdef GPIO_DEBOUNCE_EDGE_OUT_EN
        begin
            int rises, falls, bad;
            logic prev;
            rises = 0; falls = 0; bad = 0;
            prev = gpio_clean[5];
            gpio_pins[5] = 1'b1;
            repeat (25) begin
                tick();
                if (gpio_rise[5]) rises++;
                if (gpio_fall[5]) falls++;
                if (gpio_rise[5] !== (gpio_clean[5] & ~prev)) bad++;
                prev = gpio_clean[5];
            end
            check("t6_rise_count", 32'(rises), 32'd1);
            check("t6_no_fall_on_rise", 32'(falls), 32'd0);
            check("t6_rise_coincident", 32'(bad), 32'd0);
            rises = 0; falls = 0; bad = 0;
            gpio_pins[5] = 1'b0;
            repeat (25) begin
                tick();
                if (gpio_rise[5]) rises++;
                if (gpio_fall[5]) falls++;
                if (gpio_fall[5] !== (~gpio_clean[5] & prev)) bad++;
                prev = gpio_clean[5];
            end
            check("t6_fall_count", 32'(falls), 32'd1);
            check("t6_no_rise_on_fall", 32'(rises), 32'd0);
            check("t6_fall_coincident", 32'(bad), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
